// File: rtl/filt_pkg.sv
// Shared definitions for the filter sequencer: select encodings, FSM states
// and default datapath widths.
package filt_pkg;

  localparam int XADC_DATA_SIZE = 16;
  localparam int M              = 23;

  localparam logic [1:0] FILT_SEL_LPF  = 2'b00;
  localparam logic [1:0] FILT_SEL_HPF  = 2'b01;
  localparam logic [1:0] FILT_SEL_BPF  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  // The reserved encoding must never reach the datapath.
  function automatic logic sel_is_valid(input logic [1:0] sel);
    case (sel)
      FILT_SEL_LPF, FILT_SEL_HPF, FILT_SEL_BPF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/filt_sched_fifo.sv
// Synchronous sample FIFO; an AW+1-bit occupancy count separates full from empty.
module filt_sched_fifo #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/filt_sched.sv
// Sequencer between the XADC sample stream and the FIR datapath: buffers
// samples, issues one start per sample, and returns results on valid/ready.
module filt_sched #(
  parameter int XADC_DATA_SIZE  = filt_pkg::XADC_DATA_SIZE,
  parameter int FIFO_AW         = 3,
  parameter int START_PULSE_CYC = 2,
  parameter int TIMEOUT_CYC     = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  input  logic [XADC_DATA_SIZE-1:0] s_data,
  output logic                      s_ready,
  input  logic [1:0]                cfg_select,
  input  logic                      cfg_update,
  output logic                      filt_start,
  output logic [1:0]                filt_select,
  output logic [XADC_DATA_SIZE-1:0] filt_input,
  input  logic [XADC_DATA_SIZE-1:0] filt_result,
  input  logic                      filt_done,
  output logic                      m_valid,
  output logic [XADC_DATA_SIZE-1:0] m_data,
  input  logic                      m_ready,
  output logic                      busy,
  output logic [15:0]               overflow_cnt,
  output logic                      timeout_err
);

  import filt_pkg::*;

  localparam int SC_W   = $clog2(START_PULSE_CYC + 1);
  localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(START_PULSE_CYC - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYC);

  state_t state, next_state;

  logic [XADC_DATA_SIZE-1:0] fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [FIFO_AW:0]          fifo_count;
  logic                      unused_fifo_count;

  logic [SC_W-1:0]   sc;
  logic [WCNT_W-1:0] wcnt;
  logic              done_q;
  logic              done_rise;
  logic              pend_valid;
  logic [1:0]        pend_sel;
  logic              cfg_ok;

  logic pop;
  logic apply_sel;
  logic capture;
  logic abort;

  assign s_ready           = !fifo_full;
  assign done_rise         = filt_done && !done_q;
  assign cfg_ok            = cfg_update && sel_is_valid(cfg_select);
  assign unused_fifo_count = ^fifo_count;

  filt_sched_fifo #(
    .WIDTH (XADC_DATA_SIZE),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .pop   (pop),
    .wdata (s_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and per-cycle strobes; a pending select takes priority over a pop.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    apply_sel  = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (pend_valid) begin
          apply_sel = 1'b1;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = START;
        end else begin
          next_state = IDLE;
        end
      end
      START: begin
        if (sc == SC_LAST) next_state = WAIT;
        else               next_state = START;
      end
      WAIT: begin
        if (done_rise) begin
          capture    = 1'b1;
          next_state = OUT;
        end else if (wcnt == WCNT_LAST) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = WAIT;
        end
      end
      OUT: begin
        if (m_ready) next_state = IDLE;
        else         next_state = OUT;
      end
      default: next_state = IDLE;
    endcase
  end

  // Phase counters restart whenever their state is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc   <= '0;
      wcnt <= '0;
    end else begin
      sc   <= (state == START) ? sc + 1'b1 : '0;
      wcnt <= (state == WAIT)  ? wcnt + 1'b1 : '0;
    end
  end

  // Datapath-facing and downstream output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b0;
      filt_start  <= 1'b0;
      busy        <= 1'b0;
      filt_input  <= '0;
      filt_select <= FILT_SEL_LPF;
      m_valid     <= 1'b0;
      m_data      <= '0;
    end else begin
      done_q     <= filt_done;
      filt_start <= (next_state == START);
      busy       <= (next_state != IDLE);
      if (pop)       filt_input  <= fifo_rdata;
      if (apply_sel) filt_select <= pend_sel;
      if (capture) begin
        m_data  <= filt_result;
        m_valid <= 1'b1;
      end else if (state == OUT && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Pending select (last valid update wins), sticky timeout and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid   <= 1'b0;
      pend_sel     <= FILT_SEL_LPF;
      timeout_err  <= 1'b0;
      overflow_cnt <= 16'd0;
    end else begin
      if (cfg_ok) begin
        pend_valid <= 1'b1;
        pend_sel   <= cfg_select;
      end else if (apply_sel) begin
        pend_valid <= 1'b0;
      end
      if (abort)           timeout_err <= 1'b1;
      else if (cfg_update) timeout_err <= 1'b0;
      if (s_valid && fifo_full && overflow_cnt != 16'hFFFF)
        overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_filt_sched.sv
// Scoreboard bench for filt_sched: a behavioural datapath answers each start,
// expected results are queued at stimulus time and popped by an output monitor.
module tb_filt_sched;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [1:0]  cfg_select;
  logic        cfg_update;
  logic        filt_start;
  logic [1:0]  filt_select;
  logic [15:0] filt_input;
  logic [15:0] filt_result;
  logic        filt_done;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready;
  logic        busy;
  logic [15:0] overflow_cnt;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int received = 0;
  int done_cyc = 0;
  int last_start_cyc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic [1:0]  cur_sel = 2'b00;

  int          dp_lat = 5;
  bit          dp_stall = 1'b0;
  bit          dp_fixed = 1'b0;
  logic [15:0] dp_fixed_val = 16'h0000;

  filt_sched dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cfg_select(cfg_select), .cfg_update(cfg_update), .filt_start(filt_start),
    .filt_select(filt_select), .filt_input(filt_input), .filt_result(filt_result),
    .filt_done(filt_done), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .overflow_cnt(overflow_cnt), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ref_filt(input logic [15:0] x, input logic [1:0] sel);
    case (sel)
      2'b00:   return x >> 1;
      2'b01:   return ~x;
      2'b10:   return x + 16'h0101;
      default: return x;
    endcase
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=0x%0h expected=none", m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("m_data", m_data, mon_exp);
      end
      received++;
    end
  end

  // Behavioural FIR datapath: captures input/select at start, answers after a latency.
  initial begin : datapath
    logic [15:0] cin;
    logic [1:0]  csel;
    int          lat;
    int          n;
    bit          stall;
    filt_done   = 1'b0;
    filt_result = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst && filt_start) begin
        cin = filt_input;
        csel = filt_select;
        lat = dp_lat;
        stall = dp_stall;
        last_start_cyc = cyc;
        n = 1;
        @(negedge clk);
        while (filt_start && n < 8) begin
          check_eq("start_input_stable", filt_input, cin);
          check_eq("start_select_stable", filt_select, csel);
          n++;
          @(negedge clk);
        end
        check_eq("start_len", n, 2);
        if (!stall && !rst) begin
          repeat (lat) @(posedge clk);
          #1;
          filt_result = dp_fixed ? dp_fixed_val : ref_filt(cin, csel);
          filt_done = 1'b1;
          done_cyc = cyc;
          repeat (2) @(posedge clk);
          #1 filt_done = 1'b0;
        end
      end
    end
  end

  task automatic drive_sample(input logic [15:0] d, input bit expect_it, input logic [15:0] e);
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    check_eq("s_ready_on_push", s_ready, 1);
    if (expect_it) exp_q.push_back(e);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic cfg_pulse(input logic [1:0] sel);
    @(posedge clk);
    #1;
    cfg_update = 1'b1;
    cfg_select = sel;
    @(posedge clk);
    #1 cfg_update = 1'b0;
  endtask

  task automatic wait_mvalid(input string name);
    int k = 0;
    @(negedge clk);
    while (!m_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_eq(name, m_valid, 1);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_eq(name, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [15:0] hold;
    int k, sent, base, busy_seen;
    rst = 1'b1; s_valid = 1'b0; s_data = 16'h0000; cfg_select = 2'b00;
    cfg_update = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_filt_start", filt_start, 0);
    check_eq("rst_filt_select", filt_select, 0);
    check_eq("rst_filt_input", filt_input, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overflow", overflow_cnt, 0);
    check_eq("rst_timeout", timeout_err, 0);
    check_eq("rst_s_ready", s_ready, 1);

    // Single sample: start latency, pulse width and done-to-valid latency.
    dp_fixed = 1'b1; dp_fixed_val = 16'h0ABC; dp_lat = 28;
    drive_sample(16'h1234, 1'b1, 16'h0ABC);
    @(negedge clk); check_eq("t1_pop_cycle_start", filt_start, 0);
    @(negedge clk); check_eq("t1_start_hi0", filt_start, 1);
    check_eq("t1_filt_input", filt_input, 16'h1234);
    check_eq("t1_busy", busy, 1);
    @(negedge clk); check_eq("t1_start_hi1", filt_start, 1);
    @(negedge clk); check_eq("t1_start_lo", filt_start, 0);
    wait_mvalid("t1_m_valid_seen");
    check_eq("t1_valid_latency", cyc - done_cyc, 1);
    dp_fixed = 1'b0;
    wait_drain("t1_drain");

    // Burst of 10 while the datapath holds a primer sample: 8 fit, 2 dropped.
    dp_lat = 60;
    drive_sample(16'h0F0F, 1'b1, ref_filt(16'h0F0F, cur_sel));
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      s_valid = 1'b1;
      s_data  = 16'h1000 + 16'(i * 16'h0111);
      @(negedge clk);
      check_eq("burst_s_ready", s_ready, (i < 8));
      if (i < 8) exp_q.push_back(ref_filt(s_data, cur_sel));
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    check_eq("burst_overflow_cnt", overflow_cnt, 2);
    dp_lat = 5;
    wait_drain("burst_drain");

    // Select change during WAIT applies only after the in-flight sample completes.
    dp_lat = 20;
    drive_sample(16'h2222, 1'b1, ref_filt(16'h2222, 2'b00));
    repeat (4) @(negedge clk);
    cfg_pulse(2'b01);
    drive_sample(16'h3333, 1'b1, ref_filt(16'h3333, 2'b01));
    cur_sel = 2'b01;
    wait_mvalid("sel_m_valid_seen");
    check_eq("sel_hold_out", filt_select, 0);
    @(negedge clk); check_eq("sel_hold_idle", filt_select, 0);
    check_eq("sel_no_start_idle", filt_start, 0);
    @(negedge clk); check_eq("sel_applied", filt_select, 1);
    check_eq("sel_start_delayed", filt_start, 0);
    @(negedge clk); check_eq("sel_start_after", filt_start, 1);
    dp_lat = 5;
    wait_drain("sel_drain");

    // Backpressure: result held 20 cycles, no new start, FIFO still accepts.
    @(posedge clk);
    #1 m_ready = 1'b0;
    drive_sample(16'h4444, 1'b1, ref_filt(16'h4444, cur_sel));
    wait_mvalid("bp_m_valid_seen");
    hold = m_data;
    check_eq("bp_first_data", hold, ref_filt(16'h4444, cur_sel));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      s_valid = (i == 3);
      s_data  = 16'h5555;
      @(negedge clk);
      check_eq("bp_m_valid_hold", m_valid, 1);
      check_eq("bp_m_data_hold", m_data, hold);
      check_eq("bp_no_start", filt_start, 0);
      if (i == 3) begin
        check_eq("bp_s_ready", s_ready, 1);
        exp_q.push_back(ref_filt(16'h5555, cur_sel));
      end
    end
    @(posedge clk);
    #1 begin s_valid = 1'b0; m_ready = 1'b1; end
    wait_drain("bp_drain");

    // Timeout: stalled datapath sets the sticky flag, next sample still runs.
    dp_stall = 1'b1;
    drive_sample(16'h6666, 1'b0, 16'h0000);
    drive_sample(16'h7777, 1'b1, ref_filt(16'h7777, cur_sel));
    k = 0;
    @(negedge clk);
    while (!timeout_err && k < 400) begin
      @(negedge clk);
      k++;
    end
    dp_stall = 1'b0;
    check_eq("to_flag_set", timeout_err, 1);
    check_eq("to_wait_len_ok", (cyc - last_start_cyc >= 256) && (cyc - last_start_cyc <= 260), 1);
    wait_drain("to_next_sample");
    cfg_pulse(2'b11);
    @(negedge clk);
    check_eq("to_flag_cleared", timeout_err, 0);
    repeat (3) @(negedge clk);
    check_eq("rsvd_sel_ignored", filt_select, cur_sel);

    // Switch to BPF while idle, then randomized traffic and backpressure.
    cfg_pulse(2'b10);
    cur_sel = 2'b10;
    repeat (3) @(negedge clk);
    check_eq("bpf_selected", filt_select, 2);
    sent = 0; base = received; k = 0;
    while ((received - base) < 40 && k < 5000) begin
      @(posedge clk);
      #1;
      m_ready = ($urandom_range(0, 3) != 0);
      dp_lat  = $urandom_range(3, 20);
      if (sent < 40 && (sent - (received - base)) < 7 && $urandom_range(0, 1) == 1) begin
        s_valid = 1'b1;
        s_data  = 16'($urandom);
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
      if (s_valid) begin
        check_eq("rand_s_ready", s_ready, 1);
        exp_q.push_back(ref_filt(s_data, cur_sel));
        sent++;
      end
      k++;
    end
    @(posedge clk);
    #1 begin s_valid = 1'b0; m_ready = 1'b1; end
    check_eq("rand_all_received", received - base, 40);
    dp_lat = 5;

    // Asynchronous reset while a sample waits in the datapath.
    dp_stall = 1'b1;
    drive_sample(16'h8888, 1'b0, 16'h0000);
    drive_sample(16'h9999, 1'b0, 16'h0000);
    repeat (4) @(negedge clk);
    check_eq("rw_busy_before", busy, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("rw_filt_start", filt_start, 0);
    check_eq("rw_m_valid", m_valid, 0);
    check_eq("rw_busy", busy, 0);
    check_eq("rw_overflow", overflow_cnt, 0);
    check_eq("rw_filt_select", filt_select, 0);
    check_eq("rw_s_ready", s_ready, 1);
    exp_q.delete();
    cur_sel = 2'b00;
    repeat (2) @(posedge clk);
    #1 begin rst = 1'b0; dp_stall = 1'b0; end
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || filt_start) busy_seen++;
    end
    check_eq("rw_fifo_empty_after", busy_seen, 0);
    drive_sample(16'hA5A5, 1'b1, ref_filt(16'hA5A5, cur_sel));
    wait_drain("rw_post_sample");
    check_eq("rw_select_post", filt_select, 0);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filt_sched.md
Name: filt_sched

Overview:
- Sequencer placed between the XADC sample stream and the `filters` FIR datapath (M=23 taps; LPF, HPF or BPF).
- Buffers incoming samples in a small FIFO and issues one `filt_start` pulse per sample.
- Waits for `filt_done` and presents each filtered result on a valid/ready output.
- Applies filter-select changes only at sample boundaries and reports overflow and timeout conditions.

Parameters:
- XADC_DATA_SIZE, 16, sample and result width.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8.
- START_PULSE_CYC, 2, number of cycles `filt_start` is held high.
- TIMEOUT_CYC, 255, maximum cycles to wait for `filt_done` before aborting.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  XADC sample valid (free-running source).
- s_data  in  XADC_DATA_SIZE  XADC sample.
- s_ready  out  1  FIFO not full.
- cfg_select  in  2  requested filter: 00 = LPF, 01 = HPF, 10 = BPF, 11 = reserved.
- cfg_update  in  1  one-cycle pulse; latch `cfg_select` as the pending select.
- filt_start  out  1  start pulse to the datapath.
- filt_select  out  2  active filter select to the datapath.
- filt_input  out  XADC_DATA_SIZE  sample being filtered.
- filt_result  in  XADC_DATA_SIZE  datapath result.
- filt_done  in  1  datapath completion; a rising edge marks completion.
- m_valid  out  1  result valid.
- m_data  out  XADC_DATA_SIZE  filtered result.
- m_ready  in  1  downstream accept.
- busy  out  1  FSM not in IDLE.
- overflow_cnt  out  16  saturating count of samples dropped while the FIFO is full.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset values: all outputs 0; `filt_select` = 00 (LPF); pending select = 00; FIFO empty; FSM = IDLE.
- Mid-operation reset: `rst` clears everything asynchronously and drops `filt_start` immediately. Any in-flight sample and any pending output are discarded.
- FIFO input:
  - Push when `s_valid && !full`.
  - If `s_valid && full`, the sample is dropped and `overflow_cnt` increments, saturating at 0xFFFF.
  - A push is rejected when the FIFO is full even if a pop happens in the same cycle.
  - `s_ready = !full`.
  - Pointers wrap modulo depth; a FIFO_AW+1-bit count distinguishes full from empty.
- IDLE:
  - If a select change is pending, copy the pending select to `filt_select` this cycle without starting.
  - Otherwise, if the FIFO is not empty, pop the head into the `filt_input` register and go to START.
  - A select change therefore delays the next start by exactly 1 cycle.
- START:
  - `filt_start` = 1 for START_PULSE_CYC cycles, then go to WAIT.
  - `filt_input` and `filt_select` stay stable from START until WAIT exits.
- WAIT:
  - `filt_done` is registered (`done_q`); completion is `filt_done && !done_q`.
  - On completion, capture `filt_result` into `m_data`, set `m_valid`, and go to OUT.
  - The wait counter counts from 0. If it reaches TIMEOUT_CYC without completion: set `timeout_err`, discard the sample, return to IDLE, produce no output.
  - A `filt_done` level that is already high on entry to WAIT does not count as completion.
- OUT:
  - Hold `m_valid` and `m_data` until `m_ready`.
  - On the handshake, clear `m_valid` and return to IDLE; the next pop can happen on the following cycle.
  - The FIFO keeps accepting input during OUT and WAIT.
- Latency:
  - Sample pushed into an empty FIFO in cycle N: pop in N+1, `filt_start` high in cycles N+2 .. N+1+START_PULSE_CYC.
  - `filt_done` rising edge in cycle D: `m_valid` high in D+1.
- cfg_update:
  - Latches `cfg_select` as pending; a later update before it is applied overwrites it (last value wins).
  - Value 11 is ignored: no pending flag is set and `filt_select` is unchanged.
  - `cfg_update` also clears `timeout_err`.
- Simultaneous `cfg_update` and IDLE pop in the same cycle: the pop proceeds with the old select; the new select is applied after that sample completes.

Decomposition:
- Package `filt_pkg`:
  - Select encodings FILT_SEL_LPF/HPF/BPF.
  - FSM state enum {IDLE, START, WAIT, OUT}.
  - Default widths XADC_DATA_SIZE = 16, M = 23.
- Sub-module `filt_sched_fifo`: synchronous FIFO, parameterised by width and FIFO_AW, with push, pop, full, empty and count.
- FSM, done edge detection, timeout counter and output register stay in `filt_sched`.

Test Plan:
- Single sample: push 0x1234 with the datapath model returning 0x0ABC 30 cycles after start -> `filt_start` high for exactly 2 cycles with `filt_input` = 0x1234; `m_valid` rises one cycle after `filt_done` rises; `m_data` = 0x0ABC.
- Burst and overflow: push 10 consecutive samples with the datapath stalled -> 8 accepted, `s_ready` drops after the 8th, `overflow_cnt` = 2. The 8 results come out in order, matching the accepted samples.
- Select change: `cfg_update` with 01 while in WAIT -> `filt_select` stays 00 until OUT completes, becomes 01 in the next IDLE cycle, and the next start follows 1 cycle later.
- Backpressure: `m_ready` = 0 for 20 cycles -> `m_valid` and `m_data` held stable, no new `filt_start` issued, FIFO still accepts input.
- Timeout: `filt_done` never asserts -> `timeout_err` = 1 after 255 wait cycles, no `m_valid`, next sample starts; a subsequent `cfg_update` clears `timeout_err`.
- Reset mid-WAIT: assert `rst` asynchronously -> `filt_start`, `m_valid`, `busy` and `overflow_cnt` all 0 immediately, FIFO empty, `filt_select` = 00.
